// File: rtl/uart_rx_pkg.sv
// Shared definitions for the AHB-Lite UART receiver:
// register map, STATUS/CTRL bit positions, FSM encodings.
package uart_rx_pkg;

    // Register word indices (HADDR[3:2])
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // Register byte offsets
    localparam logic [7:0] OFF_DATA     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_PRESCALE = 8'h08;
    localparam logic [7:0] OFF_CTRL     = 8'h0C;

    // STATUS bit positions
    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_FERR = 3;
    localparam int STAT_CNT  = 4;

    // CTRL bit positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    // Receiver FSM encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Registered AHB data-phase information
    typedef struct packed {
        logic [1:0] idx;
        logic       rd;
        logic       wr;
    } ahb_dphase_t;

    // A zero divider would never tick; treat it as 1
    function automatic logic [15:0] eff_prescale(input logic [15:0] p);
        return (p == 16'd0) ? 16'd1 : p;
    endfunction

endpackage

// File: rtl/ahbl_uart_rx_if.sv
// AHB-Lite bus bundle for the UART receiver.
// master drives the address/data phase, slave answers.
interface ahbl_uart_rx_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE,
        output HREADY, HSEL, HWDATA,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE,
        input  HREADY, HSEL, HWDATA,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, power-of-two depth, pointers wrap naturally.
// Push while full is accepted only if a pop happens too.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign count = r_cnt;
    assign dout  = r_mem[r_rp];

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wp] <= din;
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push)
                r_wp <= r_wp + 1'b1;
            if (w_do_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1, 16x oversampling,
// receive FIFO, overrun/framing flags, level interrupt.
module ahbl_uart_rx
    import uart_rx_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd54
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahbl_uart_rx_if.slave bus,
    input  logic          rx,
    output logic          irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ahb_dphase_t r_dp;
    logic        r_en;
    logic        r_ie;
    logic [15:0] r_prescale;
    logic        r_ovr;
    logic        r_ferr;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_d;
    logic [15:0] r_pre_cnt;
    logic [1:0]  r_state;
    logic [3:0]  r_phase;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;

    logic        w_sel;
    logic        w_wr;
    logic        w_pop;
    logic        w_push;
    logic        w_fall;
    logic        w_tick;
    logic        w_start;
    logic        w_last;
    logic        w_stop_hit;
    logic        w_ferr_set;
    logic        w_ovr_set;
    logic        w_clr_ovr;
    logic        w_clr_ferr;
    logic [15:0] w_pre_eff;
    logic [7:0]  w_dout;
    logic        w_empty;
    logic        w_full;
    logic [CW-1:0] w_count;
    logic [3:0]  w_cnt4;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{bus.HADDR[31:4], bus.HADDR[1:0],
                        bus.HSIZE, bus.HTRANS[0],
                        bus.HWDATA[31:16]};

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRDATA    = w_rdata;

    assign w_sel = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_wr  = r_dp.wr & bus.HREADY;
    assign w_pop = r_dp.rd & bus.HREADY
                 & (r_dp.idx == REG_DATA) & ~w_empty;

    assign w_clr_ovr  = w_wr & (r_dp.idx == REG_STATUS)
                      & bus.HWDATA[STAT_OVR];
    assign w_clr_ferr = w_wr & (r_dp.idx == REG_STATUS)
                      & bus.HWDATA[STAT_FERR];

    assign w_fall     = r_rx_d & ~r_rx_s2;
    assign w_pre_eff  = eff_prescale(r_prescale);
    assign w_tick     = (r_pre_cnt == w_pre_eff - 16'd1);
    assign w_start    = r_en & (r_state == S_IDLE) & w_fall;
    assign w_last     = w_tick & (r_phase == 4'd15);
    assign w_stop_hit = r_en & (r_state == S_STOP) & w_last;
    assign w_push     = w_stop_hit & r_rx_s2;
    assign w_ferr_set = w_stop_hit & ~r_rx_s2;
    assign w_ovr_set  = w_push & w_full & ~w_pop;

    assign w_cnt4 = 4'(w_count);
    assign irq    = r_ie & ~w_empty;

    // Capture the address phase for use in the data phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_dp <= '0;
        end else if (bus.HREADY) begin
            r_dp.rd <= w_sel & ~bus.HWRITE;
            r_dp.wr <= w_sel & bus.HWRITE;
            if (w_sel)
                r_dp.idx <= bus.HADDR[3:2];
        end
    end

    // CTRL and PRESCALE register writes
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= PRESCALE_RST;
        end else if (w_wr) begin
            if (r_dp.idx == REG_CTRL) begin
                r_en <= bus.HWDATA[CTRL_EN];
                r_ie <= bus.HWDATA[CTRL_IE];
            end
            if (r_dp.idx == REG_PRESCALE)
                r_prescale <= bus.HWDATA[15:0];
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr  & ~w_clr_ovr)  | w_ovr_set;
            r_ferr <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
        end
    end

    // Two-flop synchronizer plus edge-detect history
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // Prescaler producing the 16x oversampling tick
    always_ff @(posedge HCLK) begin
        if (!HRESETn || w_start || w_tick)
            r_pre_cnt <= 16'd0;
        else
            r_pre_cnt <= r_pre_cnt + 16'd1;
    end

    // Receiver FSM: start validation, data shift, stop check
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_phase <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else if (!r_en) begin
            r_state <= S_IDLE;
            r_phase <= 4'd0;
            r_bit   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_phase <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_phase == 4'd7) begin
                            r_phase <= 4'd0;
                            r_bit   <= 3'd0;
                            r_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        end else begin
                            r_phase <= r_phase + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_phase <= r_phase + 4'd1;
                        if (r_phase == 4'd15) begin
                            r_shift <= {r_rx_s2, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7)
                                r_state <= S_STOP;
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_phase <= r_phase + 4'd1;
                        if (r_phase == 4'd15)
                            r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Read mux driven from the registered data-phase index
    always_comb begin
        w_rdata = 32'd0;
        if (r_dp.rd) begin
            unique case (1'b1)
                r_dp.idx == REG_DATA:
                    w_rdata[7:0] = w_empty ? 8'd0 : w_dout;
                r_dp.idx == REG_STATUS:
                    w_rdata[7:0] = {w_cnt4, r_ferr, r_ovr,
                                    w_full, ~w_empty};
                r_dp.idx == REG_PRESCALE:
                    w_rdata[15:0] = r_prescale;
                r_dp.idx == REG_CTRL:
                    w_rdata[1:0] = {r_ie, r_en};
                default:
                    w_rdata = 32'd0;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

endmodule

// File: doc/ahbl_uart_rx.md
AHBL_UART_RX -- requirements
Module: ahbl_uart_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter PRESCALE_RST, default 16'd54, reset value of the PRESCALE register.
REQ-003 The block SHALL have port HCLK  input  1  the single clock.
REQ-004 The block SHALL have port HRESETn  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have AHB-Lite slave ports HADDR in 32, HTRANS in 2, HSIZE in 3, HWRITE in 1, HREADY in 1, HSEL in 1, HWDATA in 32, HREADYOUT out 1, HRDATA out 32.
REQ-006 The block SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1.
REQ-007 The block SHALL have port irq  output  1  receive interrupt.

Function
REQ-008 The block SHALL capture the address phase (HADDR[3:2], HWRITE) only when HSEL & HTRANS[1] & HREADY; writes take effect in the data phase, and HREADYOUT SHALL be constant 1 (zero wait states).
REQ-009 The block SHALL map: 0x00 DATA (RO, [7:0] FIFO head, read pops); 0x04 STATUS ([0] not-empty, [1] full, [2] OVR, [3] FERR, [7:4] count; writing 1 to [2]/[3] clears them); 0x08 PRESCALE (RW, [15:0]); 0x0C CTRL (RW, [0] EN, [1] IE).
REQ-010 The block SHALL drive HRDATA combinationally from the registered data-phase address, with unused bits 0; a DATA read while empty SHALL return 0 and SHALL NOT pop.
REQ-011 The block SHALL pass rx through a 2-flop synchronizer, resetting both flops to 1.
REQ-012 The block SHALL generate a 1-cycle tick16 whenever a prescale counter reaches PRESCALE-1 (then reloads to 0); PRESCALE=0 SHALL be treated as 1.
REQ-013 The receiver FSM SHALL use states IDLE, START, DATA, STOP, with a 4-bit tick16 phase counter and a 3-bit bit index.
REQ-014 IDLE -> START SHALL occur on a synchronized falling edge while EN=1; phase counter and prescale counter reset to 0.
REQ-015 In START, at phase 7: rx=0 -> DATA with phase reset to 0; rx=1 -> IDLE (glitch rejected, nothing recorded).
REQ-016 In DATA, the block SHALL sample rx at phase 15 of each bit, LSB first, for 8 bits, then enter STOP.
REQ-017 In STOP at phase 15: rx=1 pushes the byte; rx=0 sets FERR and discards it; both -> IDLE.
REQ-018 A pushed byte SHALL be readable (not-empty=1) on the cycle after the stop sample.
REQ-019 A push while full with no simultaneous pop SHALL drop the byte and set OVR; push and pop in the same cycle SHALL both succeed, including when full.
REQ-020 Clearing EN mid-frame SHALL return the FSM to IDLE within one cycle and discard the partial byte; FIFO contents are kept.
REQ-021 A STATUS W1C in the same cycle as a set event SHALL leave the flag set.
REQ-022 irq SHALL equal IE & not-empty.

Reset
REQ-023 On HRESETn=0 at a HCLK edge: FSM IDLE, FIFO empty, count 0, OVR/FERR 0, EN 0, IE 0, PRESCALE=PRESCALE_RST, irq 0, HRDATA 0, HREADYOUT 1.

Structure
REQ-024 Register offsets, STATUS bit positions and FSM state encodings SHALL live in shared package uart_rx_pkg.
REQ-025 The FIFO SHALL be a sub-module uart_rx_fifo (push, pop, din, dout, empty, full, count), with pointers wrapping modulo FIFO_DEPTH.

Verification
REQ-026 PRESCALE=4, EN=1, frame 0xA5 on rx at 64 clk/bit -> STATUS=0x11, DATA read=0xA5, then STATUS=0x00.
REQ-027 rx low for 20 clocks (PRESCALE=4) -> no byte, no FERR, FSM back in IDLE.
REQ-028 Frame 0x3C with stop bit 0 -> FERR=1, FIFO empty; write STATUS 0x08 -> FERR=0.
REQ-029 Nine frames 0x01..0x09 without reads (depth 8) -> full=1, OVR=1, reads return 0x01..0x08, then empty.
REQ-030 IE=1, one frame 0x55 -> irq rises one cycle after stop sample, falls after the DATA read; EN cleared mid-DATA -> no push, FSM IDLE.
